// File: rtl/fetch_sequencer_if.sv
// Instruction-memory and decode handshakes of the fetch sequencer.
// master = sequencer side, slave = memory/decode side.
interface fetch_sequencer_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic        instr_ready;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output instr_valid,
        output instr_out,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  instr_valid,
        input  instr_out,
        output instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: RST -> REQ -> WAIT -> ISSUE loop that drives the PC controls.
// Optional WAIT/DRAIN timeout with sticky fetch_err under `FETCH_TIMEOUT_EN.
module fetch_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     restart,
    fetch_sequencer_if.master        bus,
    input  logic                     branch_req,
    input  logic                     branch_cond,
    input  logic                     jump_req,
    output logic [1:0]               pc_sel,
    output logic                     pc_branch_taken,
    output logic                     pc_jump,
    output logic                     fetch_err,
    output logic [2:0]               state_dbg
);

    // Handshakes: a transfer happens in a cycle where valid and ready are both 1;
    // valid is never withdrawn before acceptance except when restart overrides it.
    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        tmo_hit;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            ST_RST:   state_d = ST_REQ;
            ST_REQ: begin
                if (restart)                 state_d = ST_RST;
                else if (bus.imem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A response in the same cycle as restart is dropped here, nothing left to drain.
                if (restart)                 state_d = bus.imem_rsp_valid ? ST_RST : ST_DRAIN;
                else if (bus.imem_rsp_valid) begin
                    state_d = ST_ISSUE;
                    instr_d = bus.imem_rsp_data;
                end
                else if (tmo_hit)            state_d = ST_RST;
            end
            ST_ISSUE: begin
                if (restart)                 state_d = ST_RST;
                else if (bus.instr_ready)    state_d = ST_REQ;
            end
            ST_DRAIN: begin
                if (bus.imem_rsp_valid || tmo_hit) state_d = ST_RST;
            end
            default:  state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] tmo_q, tmo_d;
    logic       err_q, err_d;
    logic       in_wait_q, in_wait_d, tmo_fire;

    always_comb begin
        in_wait_q = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
        in_wait_d = (state_d == ST_WAIT) || (state_d == ST_DRAIN);
        tmo_hit   = in_wait_q && (tmo_q >= 8'(TIMEOUT_CYCLES - 1));
        // Mirrors the WAIT/DRAIN exits above: a timeout only wins when no response arrived.
        tmo_fire  = tmo_hit && !bus.imem_rsp_valid && ((state_q == ST_DRAIN) || !restart);
        tmo_d     = (in_wait_q && in_wait_d) ? tmo_q + 8'd1 : 8'd0;
        err_d     = err_q | tmo_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign tmo_hit   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // PC command is decoded from state; ISSUE adds the accept-cycle command.
    always_comb begin
        pc_sel          = 2'b01;
        pc_branch_taken = 1'b0;
        pc_jump         = 1'b0;
        if (state_q == ST_RST) begin
            pc_sel = 2'b11;
        end else if (state_q == ST_ISSUE && bus.instr_ready && !restart) begin
            if (jump_req) begin
                pc_sel  = 2'b10;
                pc_jump = 1'b1;
            end else if (branch_req) begin
                pc_sel          = 2'b01;
                pc_branch_taken = branch_cond;
            end else begin
                pc_sel = 2'b00;
            end
        end
    end

    // Dropping the request under restart avoids leaving an orphan fetch in flight.
    assign bus.imem_req_valid = (state_q == ST_REQ) && !restart;
    assign bus.instr_valid    = (state_q == ST_ISSUE);
    assign bus.instr_out      = instr_q;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: vector table of fetch transactions plus hand sequences
// for restart, stray responses, long waits / timeout and asynchronous reset.
module tb_fetch_sequencer;

    localparam int TMO =
`ifdef FETCH_TIMEOUT_EN
        4;
`else
        16;
`endif

    logic        clk;
    logic        rst_n;
    logic        restart;
    logic        branch_req;
    logic        branch_cond;
    logic        jump_req;
    logic [1:0]  pc_sel;
    logic        pc_branch_taken;
    logic        pc_jump;
    logic        fetch_err;
    logic [2:0]  state_dbg;

    fetch_sequencer_if bus ();

    fetch_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .restart         (restart),
        .bus             (bus),
        .branch_req      (branch_req),
        .branch_cond     (branch_cond),
        .jump_req        (jump_req),
        .pc_sel          (pc_sel),
        .pc_branch_taken (pc_branch_taken),
        .pc_jump         (pc_jump),
        .fetch_err       (fetch_err),
        .state_dbg       (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] data;
        int          req_dly;
        int          rsp_dly;
        int          stall;
        logic        jump;
        logic        branch;
        logic        cond;
        logic [1:0]  exp_sel;
        logic        exp_taken;
        logic        exp_jump;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        restart            = 1'b0;
        branch_req         = 1'b0;
        branch_cond        = 1'b0;
        jump_req           = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom();
        bus.instr_ready    = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_pc_sel", pc_sel, 2'b11);
        check("rst_pc_flags", {pc_branch_taken, pc_jump}, 2'b00);
        check("rst_req_valid", bus.imem_req_valid, 1'b0);
        check("rst_instr_valid", bus.instr_valid, 1'b0);
        check("rst_instr_out", bus.instr_out, 32'h0);
        check("rst_fetch_err", fetch_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_cycle_sel", pc_sel, 2'b11);
        check("rst_cycle_req", bus.imem_req_valid, 1'b0);
    endtask

    // Caller guarantees the DUT is in REQ at the next falling edge.
    task automatic run_fetch(input vec_t v);
        logic [31:0] exp;
        for (int i = 0; i <= v.req_dly; i++) begin
            @(negedge clk);
            idle_inputs();
            bus.imem_req_ready = (i == v.req_dly);
            #1;
            check("req_valid", bus.imem_req_valid, 1'b1);
            check("req_pc_hold", {pc_sel, pc_branch_taken, pc_jump}, 4'b0100);
            check("req_instr_valid", bus.instr_valid, 1'b0);
        end
        for (int i = 0; i <= v.rsp_dly; i++) begin
            @(negedge clk);
            idle_inputs();
            if (i == v.rsp_dly) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = v.data;
                exp_q.push_back(v.data);
            end
            #1;
            check("wait_idle", {bus.imem_req_valid, bus.instr_valid}, 2'b00);
        end
        for (int i = 0; i <= v.stall; i++) begin
            @(negedge clk);
            idle_inputs();
            jump_req        = v.jump;
            branch_req      = v.branch;
            branch_cond     = v.cond;
            bus.instr_ready = (i == v.stall);
            // Stray responses while stalled must not disturb the held instruction.
            bus.imem_rsp_valid = (i != v.stall);
            #1;
            check("issue_valid", bus.instr_valid, 1'b1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got empty queue expected entry at %0t", $time);
            end else if (i < v.stall) begin
                check("stall_pc_hold", {pc_sel, pc_branch_taken, pc_jump}, 4'b0100);
                check("stall_instr", bus.instr_out, exp_q[0]);
            end else begin
                exp = exp_q.pop_front();
                check("instr_out", bus.instr_out, exp);
                check("pc_cmd", {pc_sel, pc_branch_taken, pc_jump},
                      {v.exp_sel, v.exp_taken, v.exp_jump});
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        //          data          rq rs st  jmp   br    cond  sel    tkn   jmp
        vecs[0] = '{32'h0000_0013, 0, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[1] = '{$urandom(),    2, 3, 4, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
        vecs[2] = '{$urandom(),    0, 1, 0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0};
        vecs[3] = '{$urandom(),    1, 0, 1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        vecs[4] = '{$urandom(),    0, 2, 0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1};
        vecs[5] = '{$urandom(),    $urandom_range(0, 3), $urandom_range(0, 3), 2,
                    1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};

        rst_n = 1'b0;
        idle_inputs();
        apply_reset();

        for (int i = 0; i < 6; i++) run_fetch(vecs[i]);

        // Response arriving in REQ is ignored.
        @(negedge clk); idle_inputs(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hBAD0_0001; #1;
        check("stray_req", bus.imem_req_valid, 1'b1);
        @(negedge clk); idle_inputs(); #1;
        check("stray_ignored", {bus.imem_req_valid, bus.instr_valid}, 2'b10);
        run_fetch(vecs[2]);

        // Restart in WAIT, response 2 cycles later is drained.
        @(negedge clk); idle_inputs(); bus.imem_req_ready = 1'b1; #1;
        check("rw_req", bus.imem_req_valid, 1'b1);
        @(negedge clk); idle_inputs(); restart = 1'b1; #1;
        check("rw_wait", bus.instr_valid, 1'b0);
        @(negedge clk); idle_inputs(); #1;
        check("rw_drain1", {bus.instr_valid, pc_sel}, 3'b001);
        @(negedge clk); idle_inputs(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF; #1;
        check("rw_drain2", {bus.instr_valid, pc_sel}, 3'b001);
        @(negedge clk); idle_inputs(); #1;
        check("rw_rst_sel", pc_sel, 2'b11);
        check("rw_rst_valid", bus.instr_valid, 1'b0);
        @(negedge clk); idle_inputs(); #1;
        check("rw_req_again", {bus.imem_req_valid, bus.instr_valid}, 2'b10);
        run_fetch(vecs[1]);

        // Restart in ISSUE overrides the accept and any PC command.
        d = $urandom();
        @(negedge clk); idle_inputs(); bus.imem_req_ready = 1'b1; #1;
        @(negedge clk); idle_inputs(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = d; exp_q.push_back(d); #1;
        @(negedge clk); idle_inputs(); restart = 1'b1; bus.instr_ready = 1'b1; jump_req = 1'b1; #1;
        check("ri_valid", bus.instr_valid, 1'b1);
        check("ri_instr", bus.instr_out, exp_q.pop_front());
        check("ri_no_cmd", {pc_sel, pc_branch_taken, pc_jump}, 4'b0100);
        @(negedge clk); idle_inputs(); #1;
        check("ri_rst_sel", pc_sel, 2'b11);

        // Restart in REQ.
        @(negedge clk); idle_inputs(); restart = 1'b1; bus.imem_req_ready = 1'b1; #1;
        @(negedge clk); idle_inputs(); #1;
        check("rq_rst_sel", pc_sel, 2'b11);
        run_fetch(vecs[3]);

        // Long wait with no response.
        @(negedge clk); idle_inputs(); bus.imem_req_ready = 1'b1; #1;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk); idle_inputs(); #1;
            check("tmo_wait_err", fetch_err, 1'b0);
            check("tmo_wait_sel", pc_sel, 2'b01);
        end
        @(negedge clk); idle_inputs(); #1;
        check("tmo_err_set", fetch_err, 1'b1);
        check("tmo_rst_sel", pc_sel, 2'b11);
        run_fetch(vecs[0]);
        check("tmo_err_sticky", fetch_err, 1'b1);
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); idle_inputs(); #1;
            check("long_wait", {bus.imem_req_valid, bus.instr_valid, pc_sel, fetch_err}, 5'b00010);
        end
        d = $urandom();
        @(negedge clk); idle_inputs(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = d; exp_q.push_back(d); #1;
        @(negedge clk); idle_inputs(); bus.instr_ready = 1'b1; #1;
        check("long_instr", bus.instr_out, exp_q.pop_front());
        check("long_pc_cmd", {pc_sel, pc_branch_taken, pc_jump}, 4'b0000);
`endif

        // Asynchronous reset while holding an instruction in ISSUE.
        d = $urandom() | 32'h1;
        @(negedge clk); idle_inputs(); bus.imem_req_ready = 1'b1; #1;
        @(negedge clk); idle_inputs(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = d; exp_q.push_back(d); #1;
        @(negedge clk); idle_inputs(); #1;
        check("pre_rst_valid", bus.instr_valid, 1'b1);
        check("pre_rst_instr", bus.instr_out, exp_q.pop_front());
        apply_reset();
        run_fetch(vecs[5]);

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 16, giving the number of WAIT cycles before a fetch timeout (range 2..255).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The module SHALL have port restart, input, 1 bit, a request to refetch from address 0.
REQ-005 The module SHALL have port imem_req_valid, output, 1 bit, the instruction fetch request.
REQ-006 The module SHALL have port imem_req_ready, input, 1 bit, the memory's acceptance of the request.
REQ-007 The module SHALL have port imem_rsp_valid, input, 1 bit, and port imem_rsp_data, input, 32 bits, carrying the fetched instruction.
REQ-008 The module SHALL have port instr_valid, output, 1 bit, and port instr_out, output, 32 bits, presenting the held instruction to decode.
REQ-009 The module SHALL have port instr_ready, input, 1 bit, meaning decode accepts instr_out this cycle.
REQ-010 The module SHALL have port branch_req, input, 1 bit, and port branch_cond, input, 1 bit, carrying the conditional-branch request and its resolved outcome.
REQ-011 The module SHALL have port jump_req, input, 1 bit, an absolute jump request.
REQ-012 The module SHALL have ports pc_sel, output, 2 bits, pc_branch_taken, output, 1 bit, and pc_jump, output, 1 bit, driving the program counter controls.
REQ-013 The module SHALL have port fetch_err, output, 1 bit, a sticky timeout flag that is present only with FETCH_TIMEOUT_EN (see REQ-026).

Function
REQ-014 pc_sel encoding: 11 = reset to 0; 00 = PC+4; 01 with pc_branch_taken = PC+imm; 10 with pc_jump = load imm.
REQ-015 The PC HOLD command SHALL be pc_sel=01 with pc_branch_taken=0 and pc_jump=0, and it SHALL be driven in every cycle not listed in REQ-016..REQ-020.
REQ-016 The FSM states SHALL be RST, REQ, WAIT, ISSUE and DRAIN, and the RST state SHALL drive pc_sel=11 for exactly one cycle and then go to REQ.
REQ-017 In REQ, imem_req_valid=1; when imem_req_ready=1 the FSM SHALL go to WAIT, and it SHALL hold imem_req_valid until accepted.
REQ-018 In WAIT, when imem_rsp_valid=1, imem_rsp_data SHALL be latched into instr_out and the FSM SHALL go to ISSUE; a response in any other state SHALL be ignored except as in REQ-021.
REQ-019 In ISSUE, instr_valid=1 and instr_out SHALL be stable; when instr_ready=0 the FSM SHALL stay in ISSUE with PC HOLD.
REQ-020 In ISSUE with instr_ready=1, exactly one PC command SHALL be issued that cycle and the FSM SHALL go to REQ, with priority as follows:
- jump_req: pc_sel=10, pc_jump=1.
- else branch_req: pc_sel=01, pc_branch_taken=branch_cond.
- else: pc_sel=00.
REQ-021 restart SHALL take priority over all other inputs:
- In REQ or ISSUE: go to RST next cycle.
- In WAIT: go to DRAIN, where the outstanding response is discarded on imem_rsp_valid, then go to RST.
REQ-022 instr_valid SHALL be 0 in every state other than ISSUE.
REQ-023 Fetch latency SHALL be at least 3 cycles from REQ entry to instr_valid (REQ, WAIT, ISSUE), with zero-wait memory giving exactly 3.

Reset
REQ-024 When rst_n=0, the FSM SHALL be forced to RST and the outputs SHALL be:
- imem_req_valid=0, instr_valid=0, instr_out=0.
- pc_sel=11, pc_branch_taken=0, pc_jump=0.
- fetch_err=0 and the timeout counter cleared.
REQ-025 After rst_n deasserts, the first clock edge SHALL perform the RST cycle and imem_req_valid SHALL rise on the following cycle.

Configuration
REQ-026 With FETCH_TIMEOUT_EN defined:
- An 8-bit counter SHALL count cycles spent in WAIT or DRAIN and clear on leaving them.
- When the counter reaches TIMEOUT_CYCLES, fetch_err SHALL be set (sticky until reset) and the FSM SHALL go to RST.
REQ-027 Without FETCH_TIMEOUT_EN, there SHALL be no counter and fetch_err SHALL be tied to 0, and WAIT and DRAIN SHALL be left only on imem_rsp_valid.

Verification
REQ-028 Reset then zero-wait memory returning 0x00000013, with instr_ready=1 -> the following SHALL hold:
- pc_sel=11 for one cycle.
- instr_valid on the 3rd cycle after RST with instr_out=0x00000013.
- pc_sel=00 on that cycle.
REQ-029 ISSUE with instr_ready=0 for 4 cycles -> pc_sel=01 and pc_branch_taken=0 for all 4 cycles, and instr_out unchanged.
REQ-030 ISSUE with instr_ready=1, branch_req=1, branch_cond=1 and jump_req=1 -> pc_sel=10 and pc_jump=1 for one cycle, and pc_branch_taken=0.
REQ-031 restart in WAIT, then a response 0xDEADBEEF 2 cycles later -> instr_valid SHALL never assert for it, and pc_sel=11 on the cycle after DRAIN.
REQ-032 FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no response -> fetch_err=1 after 4 WAIT cycles, then RST, then REQ; fetch_err SHALL be cleared only by rst_n=0.
